// File: rtl/char_rom_mode_menu.sv
// Mode-select menu line generator: "MODE" header plus a 6-character name field, registered lookup.
// Optional blinking of the unconfirmed name field when CHAR_MENU_BLINK_EN is defined.
//
// state  | meaning
// BROWSE | next/prev step mode_sel, ok confirms
// LOCKED | selection confirmed, name field highlighted, ok releases
module char_rom_mode_menu #(
    parameter int COLS      = 16,
    parameter int ADDR_W    = 8,
    parameter int BLINK_DIV = 12500000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] char_xy,
    input  logic              rd_en,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_ok,
    output logic [6:0]        char_code,
    output logic              char_valid,
    output logic              char_inverse,
    output logic [1:0]        mode_sel,
    output logic              mode_locked
);

    typedef enum logic {
        BROWSE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [31:0] HDR_STR = "MODE";

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  mode_nxt;
    logic        blink_on;

    logic [31:0] xy;
    logic [2:0]  name_idx;
    logic [47:0] name_str;
    logic        in_name;
    logic [6:0]  code_c;
    logic        inv_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BROWSE;
            mode_sel <= 2'd0;
        end else begin
            state    <= state_nxt;
            mode_sel <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_sel;
        case (state)
            BROWSE: begin
                // ok wins over next/prev so the confirmed mode is the one on screen
                if (btn_ok)
                    state_nxt = LOCKED;
                else if (btn_next && !btn_prev)
                    mode_nxt = mode_sel + 2'd1;
                else if (btn_prev && !btn_next)
                    mode_nxt = mode_sel - 2'd1;
            end
            LOCKED: begin
                if (btn_ok)
                    state_nxt = BROWSE;
            end
            default: state_nxt = BROWSE;
        endcase
    end

    assign mode_locked = (state == LOCKED);

`ifdef CHAR_MENU_BLINK_EN
    localparam int CNT_W = $clog2(BLINK_DIV);

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;
    logic             sel_change;

    assign sel_change = (mode_nxt != mode_sel) || (state_nxt != state);

    // Any selection or lock change restarts the blink so the new name is shown immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (sel_change) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    assign blink_on = blink_phase;
`else
    // Without blinking the name field is always shown; BLINK_DIV is at least 2.
    assign blink_on = (BLINK_DIV >= 2);
`endif

    always_comb begin
        xy       = 32'(char_xy);
        name_idx = 3'(xy - 32'(COLS - 6));
        in_name  = (xy >= 32'(COLS - 6)) && (xy < 32'(COLS));
        case (mode_sel)
            2'd0:    name_str = "1 PLYR";
            2'd1:    name_str = "2 PLYR";
            2'd2:    name_str = "DEMO  ";
            default: name_str = "TRAIN ";
        endcase
        code_c = 7'h20;
        inv_c  = 1'b0;
        if (xy < 32'd4) begin
            code_c = HDR_STR[8*(3 - xy[1:0]) +: 7];
        end else if (in_name) begin
            inv_c = (state == LOCKED);
            if ((state == LOCKED) || blink_on)
                code_c = name_str[8*(5 - name_idx) +: 7];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            char_code    <= 7'h20;
            char_valid   <= 1'b0;
            char_inverse <= 1'b0;
        end else begin
            char_valid <= rd_en;
            if (rd_en) begin
                char_code    <= code_c;
                char_inverse <= inv_c;
            end
        end
    end

endmodule
